tipi_xfer_seq: RTL
==================

# tipi_xfer_seq

Serial transfer sequencer that drives the RPi side of the TIPI register shift chain. It accepts one byte-transfer command at a time from a local host: write RD/RC, or read TD/TC. It generates the `r_clk`/`r_le`/`r_rt`/`r_cd`/`r_dout` waveform that shifts data into or out of the selected TIPI register, and collects `r_din`. It sits between a host bus (SPI slave or soft CPU) and the TIPI CPLD pins, replacing bit-banged GPIO sequencing.

## Interface
Parameters:
- `HALF`, default 2: `clk` cycles per `r_clk` half-period. Legal range is ≥1.

Ports:
- `clk`: input, 1 bit. Single system clock; all logic is on its rising edge.
- `r_reset`: input, 1 bit. Reset, asynchronous and active-low.
- `x_req`: input, 1 bit. Command request. Sampled only in IDLE.
- `x_rt`: input, 1 bit. 1 = read TI-originated register (TD/TC); 0 = write RPi register (RD/RC).
- `x_cd`: input, 1 bit. 1 = data register; 0 = control register.
- `x_wdata`: input, [0:7]. Write byte; bit 0 is the MSB and is shifted first.
- `x_busy`: output, 1 bit. High from the cycle after accept through the done cycle.
- `x_done`: output, 1 bit. One-cycle pulse at command completion.
- `x_rdata`: output, [0:7]. Read result. Valid from `x_done` until the next read's done; unchanged by writes.
- `r_clk`: output, 1 bit. Shift clock to the TIPI interface.
- `r_le`: output, 1 bit. Load/latch enable.
- `r_rt`: output, 1 bit. Register direction select.
- `r_cd`: output, 1 bit. Data/control select.
- `r_dout`: output, 1 bit. Serial data into RD/RC.
- `r_din`: input, 1 bit. Serial data from TD/TC. Registered on the `r_clk` rising edge at the far side.

## Operation
- Reset (asynchronous, any state): all outputs 0 and `x_rdata`=8'h00. State becomes IDLE and counters clear. A transfer in progress is abandoned with no `x_done`.
- States:
  - IDLE: r_* outputs all 0. If `x_req`=1 at a rising edge, capture `x_rt`, `x_cd`, `x_wdata` and go to LO with pulse index p=0.
  - LO: `r_clk`=0 for HALF cycles, then go to HI.
  - HI: `r_clk`=1 for HALF cycles. Then p=p+1; if p was 8 go to DONE, else go to LO.
  - DONE: one cycle. `x_done`=1, `r_clk`=0. Return to IDLE.
- `r_rt` and `r_cd` hold the captured values from the first LO cycle through the DONE cycle. They return to 0 in IDLE.
- Every command is exactly 9 `r_clk` pulses, p=0..8.
- Write (`x_rt`=0):
  - Pulses 0–7: `r_dout`=wdata[p] for the whole pulse (LO and HI); `r_le`=0.
  - Pulse 8: `r_le`=1 for the whole pulse (latch); `r_dout`=0.
- Read (`x_rt`=1):
  - Pulse 0: `r_le`=1 for the whole pulse (parallel load).
  - Pulses 1–8: `r_le`=0.
  - `r_din` is captured into rdata[p-1] in the last cycle of HI of pulse p.
  - `x_rdata` updates only at DONE, from the shadow shift register; it never shows a partial byte.
  - `r_dout`=0 throughout.
- `x_req` outside IDLE is ignored; no queueing. The host must see `x_done` before the next command is accepted.
- `x_req` held high continuously: the next command is accepted in the IDLE cycle after DONE.
- The phase counter is `$clog2(HALF+1)` bits wide. The pulse counter is 4 bits, compared against 8. No wrap-around occurs within a command.

## Timing
- Accept edge = cycle 0. The first LO cycle is cycle 1.
- Pulse p: LO occupies cycles 1+2p·HALF … (2p+1)·HALF. HI occupies the following HALF cycles.
- `x_done` is high in cycle 18·HALF+1. With HALF=2 that is cycle 37.
- The earliest next accept is cycle 18·HALF+2. Throughput is one byte per 18·HALF+2 cycles.
- `x_busy` is high in cycles 1 … 18·HALF+1.
- Output changes on `r_dout`, `r_le`, `r_rt`, `r_cd` occur only at LO entry, never at HI entry. This gives ≥HALF cycles of setup before each `r_clk` rise.

## Test plan
- HALF=2, write RD 8'hA5 → `r_rt`=0 and `r_cd`=1 during cycles 1–37. `r_dout` per pulse is 1,0,1,0,0,1,0,1. `r_le`=1 only in cycles 33–36. `x_done` in cycle 37. `x_rdata` is unchanged.
- HALF=2, read TC with a bench model of a pload/serial-out register plus the registered `r_din` mux, preloaded 8'h3C → `r_le`=1 in cycles 1–4. `x_rdata`=8'h3C at `x_done` in cycle 37. No partial values appear on `x_rdata` before then.
- HALF=1, write RC 8'hFF, then `x_req` held high, then read TD 8'h81 → first done in cycle 19. Second command accepted in cycle 20, done in cycle 39. `x_rdata`=8'h81.
- `x_req` pulsed at cycles 5 and 20 during a busy HALF=2 write → ignored: exactly one `x_done` and 9 `r_clk` pulses.
- `r_reset` asserted in cycle 15 of a read → all r_* outputs and `x_busy` are 0 in the same cycle (asynchronous). No `x_done`. `x_rdata`=8'h00. After release, a new write of 8'h5A completes normally.

Source files
------------

// File: rtl/tipi_xfer_seq.sv
// tipi_xfer_seq: serial transfer sequencer for the RPi side of the TIPI shift chain.
// Takes one byte command at a time from a local host and runs exactly nine
// r_clk pulses. A write shifts x_wdata into RD/RC and latches it. A read
// parallel-loads TD/TC and shifts it out into x_rdata.
//
// Ports
//   clk       system clock, rising edge
//   r_reset   asynchronous active-low reset
//   x_req     command request, sampled only in IDLE
//   x_rt      1 = read TD/TC, 0 = write RD/RC
//   x_cd      1 = data register, 0 = control register
//   x_wdata   write byte, bit 0 = MSB, shifted first
//   x_busy    high from the cycle after accept through the done cycle
//   x_done    one-cycle completion pulse
//   x_rdata   last read result, updated only at done of a read
//   r_clk     shift clock to the TIPI interface
//   r_le      load/latch enable
//   r_rt      register direction select
//   r_cd      data/control select
//   r_dout    serial data into RD/RC
//   r_din     serial data from TD/TC
module tipi_xfer_seq #(
  parameter int unsigned HALF = 2
) (
  input  logic       clk,
  input  logic       r_reset,
  input  logic       x_req,
  input  logic       x_rt,
  input  logic       x_cd,
  input  logic [0:7] x_wdata,
  output logic       x_busy,
  output logic       x_done,
  output logic [0:7] x_rdata,
  output logic       r_clk,
  output logic       r_le,
  output logic       r_rt,
  output logic       r_cd,
  output logic       r_dout,
  input  logic       r_din
);

  localparam int unsigned PW = $clog2(HALF + 1);
  localparam logic [PW-1:0] PH_LAST = PW'(HALF - 1);
  localparam logic [3:0] P_LAST = 4'd8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LO   = 2'd1,
    HI   = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t        state, state_n;
  logic [PW-1:0] phase, phase_n;
  logic [3:0]    pulse, pulse_n;
  logic [0:7]    cmd_wdata, cmd_wdata_n;
  logic [0:7]    shadow, shadow_n;
  logic [0:7]    rdata_n;
  logic          busy_n, done_n, clk_n, le_n, rt_n, cd_n, dout_n;

  // Latch enable for pulse p: pulse 0 loads TD/TC on a read, pulse 8 latches RD/RC on a write.
  function automatic logic pulse_le(input logic rt, input logic [3:0] p);
    return rt ? (p == 4'd0) : (p == P_LAST);
  endfunction

  // Serial write data for pulse p; zero on reads and on the latch pulse.
  function automatic logic pulse_dout(input logic rt, input logic [0:7] wd, input logic [3:0] p);
    return (!rt && (p < P_LAST)) ? wd[p[2:0]] : 1'b0;
  endfunction

  // State, counters and registered outputs.
  always_ff @(posedge clk or negedge r_reset) begin
    if (!r_reset) begin
      state     <= IDLE;
      phase     <= '0;
      pulse     <= '0;
      cmd_wdata <= '0;
      shadow    <= '0;
      x_rdata   <= '0;
      x_busy    <= 1'b0;
      x_done    <= 1'b0;
      r_clk     <= 1'b0;
      r_le      <= 1'b0;
      r_rt      <= 1'b0;
      r_cd      <= 1'b0;
      r_dout    <= 1'b0;
    end else begin
      state     <= state_n;
      phase     <= phase_n;
      pulse     <= pulse_n;
      cmd_wdata <= cmd_wdata_n;
      shadow    <= shadow_n;
      x_rdata   <= rdata_n;
      x_busy    <= busy_n;
      x_done    <= done_n;
      r_clk     <= clk_n;
      r_le      <= le_n;
      r_rt      <= rt_n;
      r_cd      <= cd_n;
      r_dout    <= dout_n;
    end
  end

  // Next state and next output values. Pins are computed for the state being
  // entered, so r_le/r_dout only change on LO entry and stay put through HI.
  always_comb begin
    state_n     = state;
    phase_n     = phase;
    pulse_n     = pulse;
    cmd_wdata_n = cmd_wdata;
    shadow_n    = shadow;
    rdata_n     = x_rdata;
    busy_n      = 1'b1;
    done_n      = 1'b0;
    clk_n       = 1'b0;
    le_n        = r_le;
    rt_n        = r_rt;
    cd_n        = r_cd;
    dout_n      = r_dout;

    case (state)
      IDLE: begin
        busy_n = 1'b0;
        le_n   = 1'b0;
        rt_n   = 1'b0;
        cd_n   = 1'b0;
        dout_n = 1'b0;
        if (x_req) begin
          state_n     = LO;
          phase_n     = '0;
          pulse_n     = '0;
          cmd_wdata_n = x_wdata;
          busy_n      = 1'b1;
          rt_n        = x_rt;
          cd_n        = x_cd;
          le_n        = pulse_le(x_rt, 4'd0);
          dout_n      = pulse_dout(x_rt, x_wdata, 4'd0);
        end
      end

      LO: begin
        if (phase == PH_LAST) begin
          state_n = HI;
          phase_n = '0;
          clk_n   = 1'b1;
        end else begin
          phase_n = phase + PW'(1);
        end
      end

      HI: begin
        clk_n = 1'b1;
        if (phase == PH_LAST) begin
          phase_n = '0;
          clk_n   = 1'b0;
          // Far side registers r_din on the previous rise, so pulse p carries bit p-1.
          if (r_rt && (pulse != 4'd0)) begin
            shadow_n = {shadow[1:7], r_din};
          end
          if (pulse == P_LAST) begin
            state_n = DONE;
            done_n  = 1'b1;
            le_n    = 1'b0;
            dout_n  = 1'b0;
            if (r_rt) begin
              rdata_n = shadow_n;
            end
          end else begin
            state_n = LO;
            pulse_n = pulse + 4'd1;
            le_n    = pulse_le(r_rt, pulse_n);
            dout_n  = pulse_dout(r_rt, cmd_wdata, pulse_n);
          end
        end else begin
          phase_n = phase + PW'(1);
        end
      end

      DONE: begin
        state_n = IDLE;
        busy_n  = 1'b0;
        le_n    = 1'b0;
        rt_n    = 1'b0;
        cd_n    = 1'b0;
        dout_n  = 1'b0;
      end

      default: begin
        state_n = IDLE;
        busy_n  = 1'b0;
      end
    endcase
  end

endmodule
